// File: rtl/port_arb_pkg.sv
// Shared encodings for the port-select arbiter: FSM states, cfg bit
// positions and status-word field offsets.
package port_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        GUARD  = 2'd2,
        MANUAL = 2'd3
    } state_t;

    localparam int CFG_MANUAL = 7;

    localparam int ST_ANY_REQ = 0;
    localparam int ST_MANUAL  = 1;
    localparam int ST_OWNER   = 2;
    localparam int ST_OWNER_W = 3;
    localparam int ST_BUSY    = 5;
    localparam int ST_STATE   = 6;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         valid
);

    logic [W-1:0] idx;

    // Walk from the farthest candidate back toward ptr so the closest one wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(ptr) + i) % N);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_arb.sv
// Request/grant sequencer for the shared port-select lines with dead-time,
// hold-limit preemption and a firmware manual-override mode.
module port_arb
    import port_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int GUARD_CYC = 2,
    parameter int MAX_HOLD  = 64,
    parameter int HOLD_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] sel,
    output logic             preempt,
    input  logic             en,
    input  logic             wr,
    input  logic [7:0]       data_o,
    output logic [7:0]       data_i
);

    localparam int OW = idx_w(N_REQ);
    localparam int GW = idx_w(GUARD_CYC);

    state_t            state;
    logic [7:0]        cfg;
    logic [OW-1:0]     rr_ptr;
    logic [OW-1:0]     owner;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GW-1:0]     guard_cnt;

    logic [7:0]        cfg_nxt;
    logic [OW-1:0]     pick_win;
    logic              pick_vld;
    logic [N_REQ-1:0]  win_oh;
    logic [N_REQ-1:0]  own_oh;
    logic [OW-1:0]     rr_next;
    logic              guard_done;
    logic              arb_free;
    logic              unused_cfg_bits;

    rr_pick #(.N(N_REQ), .W(OW)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .winner (pick_win),
        .valid  (pick_vld)
    );

    // Same-cycle bus writes are seen by entry/exit of manual mode.
    assign cfg_nxt    = (en && wr) ? data_o : cfg;
    assign win_oh     = N_REQ'(1) << pick_win;
    assign own_oh     = N_REQ'(1) << owner;
    assign rr_next    = (pick_win == OW'(N_REQ - 1)) ? '0 : pick_win + 1'b1;
    assign guard_done = (guard_cnt == GW'(GUARD_CYC - 1));
    assign arb_free   = (state == IDLE) || (state == GUARD && guard_done);
    assign unused_cfg_bits = ^cfg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            preempt   <= 1'b0;
            cfg       <= 8'h00;
            rr_ptr    <= '0;
            owner     <= '0;
            hold_cnt  <= '0;
            guard_cnt <= '0;
        end else begin
            if (en && wr)
                cfg <= data_o;
            preempt <= 1'b0;

            case (state)
                GRANT: begin
                    if (hold_cnt != '1)
                        hold_cnt <= hold_cnt + 1'b1;
                    if (!(|(req & own_oh))) begin
                        state     <= GUARD;
                        gnt       <= '0;
                        sel       <= '0;
                        guard_cnt <= '0;
                    end else if (hold_cnt == HOLD_W'(MAX_HOLD - 1) && |(req & ~own_oh)) begin
                        state     <= GUARD;
                        gnt       <= '0;
                        sel       <= '0;
                        guard_cnt <= '0;
                        preempt   <= 1'b1;
                    end
                end
                GUARD: begin
                    if (!guard_done)
                        guard_cnt <= guard_cnt + 1'b1;
                end
                MANUAL: begin
                    gnt <= '0;
                    if (cfg_nxt[CFG_MANUAL]) begin
                        sel <= cfg_nxt[N_REQ-1:0];
                    end else begin
                        state     <= GUARD;
                        sel       <= '0;
                        guard_cnt <= '0;
                    end
                end
                default: ;
            endcase

            // Idle, or end of dead-time: manual mode beats pending requests.
            if (arb_free) begin
                if (cfg_nxt[CFG_MANUAL]) begin
                    state <= MANUAL;
                    gnt   <= '0;
                    sel   <= cfg_nxt[N_REQ-1:0];
                end else if (pick_vld) begin
                    state    <= GRANT;
                    gnt      <= win_oh;
                    sel      <= win_oh;
                    owner    <= pick_win;
                    hold_cnt <= '0;
                    rr_ptr   <= rr_next;
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

    always_comb begin
        data_i                          = '0;
        data_i[ST_ANY_REQ]              = |req;
        data_i[ST_MANUAL]               = cfg[CFG_MANUAL];
        data_i[ST_OWNER +: ST_OWNER_W]  = ST_OWNER_W'(owner);
        data_i[ST_BUSY]                 = (state != IDLE);
        data_i[ST_STATE +: 2]           = state;
    end

endmodule

// File: tb/tb_port_arb.sv
// Directed self-checking bench for port_arb: grant/release, round robin,
// preemption, manual override, deferred manual and async reset.
module tb_port_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, wr;
    logic [2:0] req, gnt, sel;
    logic       preempt;
    logic [7:0] data_o, data_i;

    int checks = 0;
    int errors = 0;
    int pre_cnt;
    logic [2:0] rr_exp [4];

    port_arb #(.N_REQ(3), .GUARD_CYC(2), .MAX_HOLD(64), .HOLD_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .sel     (sel),
        .preempt (preempt),
        .en      (en),
        .wr      (wr),
        .data_o  (data_o),
        .data_i  (data_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; en = 1'b0; wr = 1'b0; data_o = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic bus_write(input logic [7:0] d);
        en = 1'b1; wr = 1'b1; data_o = d;
        tick(1);
        en = 1'b0; wr = 1'b0; data_o = '0;
    endtask

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

        // Reset state
        do_reset();
        chk("rst_gnt", 8'(gnt), 8'h00);
        chk("rst_sel", 8'(sel), 8'h00);
        chk("rst_pre", 8'(preempt), 8'h00);
        chk("rst_status", data_i, 8'h00);

        // Basic grant / release
        req = 3'b001;
        tick(1);
        chk("basic_gnt", 8'(gnt), 8'h01);
        chk("basic_sel", 8'(sel), 8'h01);
        chk("basic_status", data_i, 8'h61);
        tick(4);
        chk("basic_hold", 8'(sel), 8'h01);
        req = 3'b000;
        tick(1);
        chk("basic_guard1", 8'(sel), 8'h00);
        chk("basic_guard_st", data_i, 8'hA0);
        tick(1);
        chk("basic_guard2", 8'(sel), 8'h00);
        tick(1);
        chk("basic_idle", data_i, 8'h00);

        // Round robin from a fresh pointer
        do_reset();
        req = 3'b111;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_gnt%0d", k), 8'(gnt), 8'(rr_exp[k]));
            chk($sformatf("rr_sel%0d", k), 8'(sel), 8'(rr_exp[k]));
            tick(2);
            chk($sformatf("rr_held%0d", k), 8'(gnt), 8'(rr_exp[k]));
            req = 3'b111 & ~rr_exp[k];
            tick(1);
            chk($sformatf("rr_gap_a%0d", k), 8'(sel), 8'h00);
            tick(1);
            chk($sformatf("rr_gap_b%0d", k), 8'(sel), 8'h00);
            req = (k == 3) ? 3'b000 : 3'b111;
            tick(1);
        end
        chk("rr_idle", data_i, 8'h00);

        // Preemption at the hold limit
        do_reset();
        req = 3'b001;
        tick(1);
        chk("pre_gnt0", 8'(gnt), 8'h01);
        tick(9);
        req = 3'b011;
        tick(54);
        chk("pre_last_gnt", 8'(gnt), 8'h01);
        chk("pre_not_yet", 8'(preempt), 8'h00);
        tick(1);
        chk("pre_drop_gnt", 8'(gnt), 8'h00);
        chk("pre_pulse", 8'(preempt), 8'h01);
        tick(1);
        chk("pre_pulse_end", 8'(preempt), 8'h00);
        chk("pre_guard2", 8'(sel), 8'h00);
        tick(1);
        chk("pre_new_gnt", 8'(gnt), 8'h02);
        chk("pre_status", data_i, 8'h65);

        // Sole holder is never preempted
        req = 3'b010;
        pre_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (preempt) pre_cnt++;
        end
        chk("sole_no_pre", 8'(pre_cnt), 8'h00);
        chk("sole_gnt", 8'(gnt), 8'h02);

        // Owner release coinciding with the preempt condition
        do_reset();
        req = 3'b011;
        tick(1);
        chk("sim_gnt0", 8'(gnt), 8'h01);
        tick(63);
        chk("sim_last_gnt", 8'(gnt), 8'h01);
        req = 3'b010;
        tick(1);
        chk("sim_drop", 8'(gnt), 8'h00);
        chk("sim_no_pre", 8'(preempt), 8'h00);
        tick(2);
        chk("sim_next", 8'(gnt), 8'h02);

        // Manual override
        do_reset();
        bus_write(8'h85);
        chk("man_sel", 8'(sel), 8'h05);
        chk("man_gnt", 8'(gnt), 8'h00);
        chk("man_status", data_i, 8'hE2);
        req = 3'b010;
        tick(1);
        chk("man_ignore", 8'(sel), 8'h05);
        chk("man_ignore_gnt", 8'(gnt), 8'h00);
        bus_write(8'h00);
        chk("man_exit_sel", 8'(sel), 8'h00);
        chk("man_exit_st", data_i, 8'hA1);
        tick(1);
        chk("man_guard2", 8'(sel), 8'h00);
        tick(1);
        chk("man_grant", 8'(gnt), 8'h02);
        chk("man_grant_sel", 8'(sel), 8'h02);

        // Manual request deferred until the grant ends
        do_reset();
        req = 3'b100;
        tick(1);
        chk("def_sel", 8'(sel), 8'h04);
        bus_write(8'h81);
        chk("def_hold_sel", 8'(sel), 8'h04);
        chk("def_status", data_i, 8'h6B);
        tick(2);
        chk("def_still", 8'(sel), 8'h04);
        req = 3'b001;
        tick(1);
        chk("def_guard1", 8'(sel), 8'h00);
        tick(1);
        chk("def_guard2", 8'(sel), 8'h00);
        tick(1);
        chk("def_manual", 8'(sel), 8'h01);
        chk("def_manual_gnt", 8'(gnt), 8'h00);

        // Asynchronous reset in the middle of a grant
        do_reset();
        req = 3'b001;
        tick(1);
        chk("ar_sel", 8'(sel), 8'h01);
        bus_write(8'h81);
        chk("ar_status", data_i, 8'h63);
        #2 rst = 1'b1;
        #1;
        chk("ar_sel0", 8'(sel), 8'h00);
        chk("ar_gnt0", 8'(gnt), 8'h00);
        chk("ar_pre0", 8'(preempt), 8'h00);
        chk("ar_status0", data_i, 8'h01);
        req = 3'b000;
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("ar_after", data_i, 8'h00);
        chk("ar_after_sel", 8'(sel), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
